// File: rtl/bp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_pkg                                                           |
// | Opcodes, 2-bit counter states and immediate helpers for the BP.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bp_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bimodal_branch_predictor_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bimodal_branch_predictor_if                                      |
// | IF lookup, EX resolve and perf-counter signals of the predictor. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface bimodal_branch_predictor_if;

    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] branch_pc;
    logic        branch_resolved;
    logic        branch_is_cond;
    logic        branch_taken_actual;
    logic [31:0] branch_target_actual;
    logic        branch_pred_taken;
    logic [31:0] branch_pred_target;
    logic        prediction;
    logic [31:0] predicted_target;
    logic        is_branch_instruction;
    logic        is_jump_instruction;
    logic        misprediction;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output pc, instruction, branch_pc, branch_resolved, branch_is_cond,
               branch_taken_actual, branch_target_actual, branch_pred_taken, branch_pred_target,
        input  prediction, predicted_target, is_branch_instruction, is_jump_instruction,
               misprediction, branch_count, mispredict_count
    );

    modport slave (
        input  pc, instruction, branch_pc, branch_resolved, branch_is_cond,
               branch_taken_actual, branch_target_actual, branch_pred_taken, branch_pred_target,
        output prediction, predicted_target, is_branch_instruction, is_jump_instruction,
               misprediction, branch_count, mispredict_count
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter_table.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter_table                                                |
// | 2-bit saturating counters: async read, sync write, sync reset.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT       = WNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [1:0]            rd_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0] r_ctr [DEPTH];

    assign rd_ctr = r_ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= INIT;
            end
        end else if (wr_en) begin
            r_ctr[wr_idx] <= sat2_next(r_ctr[wr_idx], wr_taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bimodal_branch_predictor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bimodal_branch_predictor                                         |
// | Bimodal direction predictor with tagged BTB and perf counters.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bimodal_branch_predictor
    import bp_pkg::*;
#(
    parameter int         INDEX_BITS   = 6,
    parameter int         TAG_BITS     = 8,
    parameter logic [1:0] COUNTER_INIT = WNT,
    parameter bit         BTB_ENABLE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    bimodal_branch_predictor_if.slave bus
);

    localparam int DEPTH   = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 2;

    logic [INDEX_BITS-1:0] w_idx;
    logic [INDEX_BITS-1:0] w_uidx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [TAG_BITS-1:0]   w_utag;
    logic                  w_update;
    logic                  w_btb_write;
    logic                  w_hit;
    logic [31:0]           w_btb_target;
    logic [1:0]            w_ctr;
    logic                  w_pred;
    logic [31:0]           w_target;
    logic                  w_is_branch;
    logic                  w_is_jump;
    logic                  w_mispredict;
    logic                  w_unused_bits;
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;

    assign w_idx       = bus.pc[INDEX_BITS+1:2];
    assign w_tag       = bus.pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign w_uidx      = bus.branch_pc[INDEX_BITS+1:2];
    assign w_utag      = bus.branch_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
    assign w_update    = bus.branch_resolved && !rst;
    assign w_btb_write = w_update && bus.branch_taken_actual;
    assign w_unused_bits = ^{bus.branch_pc[31:TAG_LSB+TAG_BITS], bus.branch_pc[1:0], w_ctr[0]};

    sat_counter_table #(
        .INDEX_BITS (INDEX_BITS),
        .INIT       (COUNTER_INIT)
    ) u_ctr_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (w_idx),
        .rd_ctr   (w_ctr),
        .wr_en    (w_update && bus.branch_is_cond),
        .wr_idx   (w_uidx),
        .wr_taken (bus.branch_taken_actual)
    );

    generate
        if (BTB_ENABLE) begin : g_btb
            logic [DEPTH-1:0]    r_valid;
            logic [TAG_BITS-1:0] r_tag    [DEPTH];
            logic [31:0]         r_target [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                end else if (w_btb_write) begin
                    r_valid[w_uidx] <= 1'b1;
                end
            end

            // Tag/target need no reset: the valid bit gates every use.
            always_ff @(posedge clk) begin
                if (w_btb_write) begin
                    r_tag[w_uidx]    <= w_utag;
                    r_target[w_uidx] <= bus.branch_target_actual;
                end
            end

            assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
            assign w_btb_target = r_target[w_idx];
        end else begin : g_no_btb
            assign w_hit        = 1'b0;
            assign w_btb_target = '0;
        end
    endgenerate

    always_comb begin
        w_pred      = 1'b0;
        w_target    = bus.pc + 32'd4;
        w_is_branch = 1'b0;
        w_is_jump   = 1'b0;
        if (!rst) begin
            case (bus.instruction[6:0])
                OP_BRANCH: begin
                    w_is_branch = 1'b1;
                    w_pred      = w_ctr[1];
                    w_target    = w_hit ? w_btb_target : bus.pc + imm_b(bus.instruction);
                end
                OP_JAL: begin
                    w_is_jump = 1'b1;
                    w_pred    = 1'b1;
                    w_target  = bus.pc + imm_j(bus.instruction);
                end
                OP_JALR: begin
                    w_is_jump = 1'b1;
                    w_pred    = w_hit;
                    w_target  = w_btb_target;
                end
                default: ;
            endcase
        end
    end

    assign w_mispredict = w_update &&
        ((bus.branch_taken_actual != bus.branch_pred_taken) ||
         (bus.branch_taken_actual && (bus.branch_target_actual != bus.branch_pred_target)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bus.branch_resolved) begin
            if (r_branch_count != 32'hFFFF_FFFF) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign bus.prediction            = w_pred;
    assign bus.predicted_target      = w_target;
    assign bus.is_branch_instruction = w_is_branch;
    assign bus.is_jump_instruction   = w_is_jump;
    assign bus.misprediction         = w_mispredict;
    assign bus.branch_count          = r_branch_count;
    assign bus.mispredict_count      = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_bimodal_branch_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_bimodal_branch_predictor                                      |
// | Directed and random stimulus against a behavioural table model.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bimodal_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bimodal_branch_predictor_if bus();

    bimodal_branch_predictor #(
        .INDEX_BITS   (6),
        .TAG_BITS     (8),
        .COUNTER_INIT (2'b01),
        .BTB_ENABLE   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] JAL_P8  = 32'h0080_006F;
    localparam logic [31:0] JALR_RA = 32'h0000_8067;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_ctr     [64];
    bit          m_valid   [64];
    bit          m_written [64];
    logic [31:0] m_tag     [64];
    logic [31:0] m_tgt     [64];
    logic [31:0] m_bcnt = 0;
    logic [31:0] m_mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int b_off(input logic [31:0] i);
        return (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    endfunction

    function automatic int j_off(input logic [31:0] i);
        return (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    endfunction

    function automatic logic model_misp();
        return bus.branch_resolved && !rst &&
            ((bus.branch_taken_actual != bus.branch_pred_taken) ||
             (bus.branch_taken_actual && bus.branch_target_actual != bus.branch_pred_target));
    endfunction

    // Reference model: compare at negedge, advance state at posedge.
    initial begin : compare
        int          idx;
        int          u;
        logic [31:0] tag;
        logic [6:0]  op;
        logic        ep;
        logic        eb;
        logic        ej;
        logic        known;
        logic        hit;
        logic [31:0] et;
        forever begin
            @(negedge clk);
            idx   = int'((bus.pc / 4) % 64);
            tag   = (bus.pc / 256) % 256;
            hit   = m_valid[idx] && (m_tag[idx] == tag);
            op    = bus.instruction[6:0];
            ep    = 1'b0;
            eb    = 1'b0;
            ej    = 1'b0;
            known = 1'b1;
            et    = bus.pc + 32'd4;
            if (!rst) begin
                if (op == 7'h63) begin
                    eb = 1'b1;
                    ep = (m_ctr[idx] >= 2);
                    et = hit ? m_tgt[idx] : bus.pc + 32'(b_off(bus.instruction));
                end else if (op == 7'h6F) begin
                    ej = 1'b1;
                    ep = 1'b1;
                    et = bus.pc + 32'(j_off(bus.instruction));
                end else if (op == 7'h67) begin
                    ej    = 1'b1;
                    ep    = hit;
                    known = m_written[idx];
                    et    = m_tgt[idx];
                end
            end
            chk("prediction", {31'd0, bus.prediction}, {31'd0, ep});
            if (known) chk("predicted_target", bus.predicted_target, et);
            chk("is_branch", {31'd0, bus.is_branch_instruction}, {31'd0, eb});
            chk("is_jump", {31'd0, bus.is_jump_instruction}, {31'd0, ej});
            chk("misprediction", {31'd0, bus.misprediction}, {31'd0, model_misp()});
            chk("branch_count", bus.branch_count, m_bcnt);
            chk("mispredict_count", bus.mispredict_count, m_mcnt);

            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_ctr[i]   = 1;
                    m_valid[i] = 1'b0;
                end
                m_bcnt = 0;
                m_mcnt = 0;
            end else if (bus.branch_resolved) begin
                if (model_misp() && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
                if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
                u = int'((bus.branch_pc / 4) % 64);
                if (bus.branch_is_cond) begin
                    if (bus.branch_taken_actual) m_ctr[u] = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
                    else                         m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
                end
                if (bus.branch_taken_actual) begin
                    m_valid[u]   = 1'b1;
                    m_written[u] = 1'b1;
                    m_tag[u]     = (bus.branch_pc / 256) % 256;
                    m_tgt[u]     = bus.branch_target_actual;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] p, input logic [31:0] ins);
        bus.pc          = p;
        bus.instruction = ins;
    endtask

    task automatic res(input logic v, input logic [31:0] bpc, input logic cond, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.branch_resolved      = v;
        bus.branch_pc            = bpc;
        bus.branch_is_cond       = cond;
        bus.branch_taken_actual  = tk;
        bus.branch_target_actual = tgt;
        bus.branch_pred_taken    = ptk;
        bus.branch_pred_target   = ptgt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            6:       return {r[31:2], 2'b00};
            7:       return 32'hFFFF_FF00 | (32'($urandom_range(0, 63)) << 2);
            default: return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
        endcase
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       op = 7'h63;
            1:       op = 7'h6F;
            2:       op = 7'h67;
            default: op = 7'h13;
        endcase
        return {r[31:7], op};
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 ns reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] t;
        look(32'h100, JAL_P8);
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pred", {31'd0, bus.prediction}, 32'd0);
        chk("rst_target", bus.predicted_target, 32'h104);
        chk("rst_is_jump", {31'd0, bus.is_jump_instruction}, 32'd0);
        step();
        step();

        // Reset state lookups
        rst = 1'b0;
        look(32'h100, BEQ_P16);
        #1;
        chk("t1_beq_pred", {31'd0, bus.prediction}, 32'd0);
        chk("t1_beq_target", bus.predicted_target, 32'h110);
        chk("t1_is_branch", {31'd0, bus.is_branch_instruction}, 32'd1);
        chk("t1_bcnt", bus.branch_count, 32'd0);
        chk("t1_mcnt", bus.mispredict_count, 32'd0);
        look(32'h100, BEQ_M8);
        #1;
        chk("t1_beq_neg_target", bus.predicted_target, 32'hF8);
        look(32'h100, JAL_P8);
        #1;
        chk("t1_jal_pred", {31'd0, bus.prediction}, 32'd1);
        chk("t1_jal_target", bus.predicted_target, 32'h108);

        // Counter training and saturation at both ends
        look(32'h100, BEQ_P16);
        res(1, 32'h100, 1, 1, 32'h110, 1, 32'h110);
        step();
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_taken_x2_pred", {31'd0, bus.prediction}, 32'd1);
        res(1, 32'h100, 1, 0, 32'h0, 0, 32'h0);
        step();
        #1;
        chk("t2_nt_x1_pred", {31'd0, bus.prediction}, 32'd1);
        step();
        step();
        step();
        res(1, 32'h100, 1, 1, 32'h110, 1, 32'h110);
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_floor_pred", {31'd0, bus.prediction}, 32'd0);
        chk("t2_bcnt", bus.branch_count, 32'd7);

        // JALR through the BTB, then an alias with another tag
        look(32'h200, JALR_RA);
        res(1, 32'h200, 0, 1, 32'h8000, 0, 32'h0);
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_jalr_pred", {31'd0, bus.prediction}, 32'd1);
        chk("t3_jalr_target", bus.predicted_target, 32'h8000);
        look(32'h300, JALR_RA);
        #1;
        chk("t3_alias_pred", {31'd0, bus.prediction}, 32'd0);
        chk("t3_mcnt", bus.mispredict_count, 32'd1);

        // Mispredict compare
        res(1, 32'h400, 1, 1, 32'h44, 1, 32'h40);
        #1;
        chk("t4_wrong_target", {31'd0, bus.misprediction}, 32'd1);
        step();
        res(1, 32'h400, 1, 0, 32'h1234, 0, 32'h40);
        #1;
        chk("t4_nt_correct", {31'd0, bus.misprediction}, 32'd0);
        chk("t4_mcnt", bus.mispredict_count, 32'd2);
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t4_bcnt", bus.branch_count, 32'd10);

        // Same-cycle lookup/update on index 5 sees the old state
        look(32'h14, BEQ_P16);
        res(1, 32'h14, 1, 1, 32'h9000, 1, 32'h9000);
        #1;
        chk("t5_same_pred", {31'd0, bus.prediction}, 32'd0);
        chk("t5_same_target", bus.predicted_target, 32'h24);
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_next_pred", {31'd0, bus.prediction}, 32'd1);
        chk("t5_next_target", bus.predicted_target, 32'h9000);

        // Reset with a resolve in flight
        rst = 1'b1;
        res(1, 32'h14, 1, 1, 32'h9000, 0, 32'h0);
        #1;
        chk("t6_rst_misp", {31'd0, bus.misprediction}, 32'd0);
        step();
        rst = 1'b0;
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t6_ctr_reset_pred", {31'd0, bus.prediction}, 32'd0);
        chk("t6_valid_cleared", bus.predicted_target, 32'h24);
        chk("t6_bcnt", bus.branch_count, 32'd0);
        chk("t6_mcnt", bus.mispredict_count, 32'd0);

        // Perf-counter saturation from a preloaded value
        dut.r_branch_count     <= 32'hFFFF_FFFE;
        dut.r_mispredict_count <= 32'hFFFF_FFFE;
        m_bcnt = 32'hFFFF_FFFE;
        m_mcnt = 32'hFFFF_FFFE;
        res(1, 32'h400, 0, 1, 32'h44, 0, 32'h40);
        step();
        #1;
        chk("sat_bcnt_max", bus.branch_count, 32'hFFFF_FFFF);
        chk("sat_mcnt_max", bus.mispredict_count, 32'hFFFF_FFFF);
        step();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_bcnt_hold", bus.branch_count, 32'hFFFF_FFFF);
        chk("sat_mcnt_hold", bus.mispredict_count, 32'hFFFF_FFFF);

        // Random traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            look(rand_pc(), rand_insn());
            t = $urandom();
            res(($urandom_range(0, 1) == 1), rand_pc(), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), {t[31:1], 1'b0}, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1) ? {t[31:1], 1'b0} : $urandom());
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        res(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
